ray_aabb_hit_collector: RTL and testbench

- Sits directly downstream of the two greater_or_equal comparators in the Ray-AABB 11/17 datapath.
- Comparator A evaluates tExitMin >= tEntryMax; comparator B evaluates tExitMin >= 0.
- Tracks each ray issued into the comparators through a latency-matched tag pipeline and samples both comparator flags when that ray's result arrives.
- Forms the hit bit and buffers results in a small FIFO with valid/ready output. Credit-based input ready, because the comparators cannot stall.

---
 rtl/ray_aabb_hit_collector.sv | 150 +++++++++++++++
 tb/tb_ray_aabb_hit_collector.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_aabb_hit_collector.sv
// Collects greater_or_equal comparator flags for rays issued into the Ray-AABB datapath,
// forms the hit bit and buffers {id, hit} results in a credit-protected FWFT FIFO.
module ray_aabb_hit_collector #(
    parameter int LAT   = 3,
    parameter int ID_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic            ge_exit_entry,
    input  logic            ge_exit_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic            out_hit,
    output logic [15:0]     hit_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LAT-1:0]  tag_v_q, tag_v_d;
    logic [ID_W-1:0] tag_id_q [LAT];
    logic [ID_W-1:0] tag_id_d [LAT];

    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ID_W:0]   mem_q [DEPTH];
    logic [ID_W:0]   mem_d [DEPTH];
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic            out_hit_q, out_hit_d;
    logic [15:0]     hit_count_q, hit_count_d;

    logic            acc, arr, push, pop, full;
    logic [ID_W:0]   push_data;
    logic [CW:0]     occupancy;

    // Credits cover both buffered results and rays still inside the comparator pipeline.
    always_comb begin
        occupancy = {1'b0, count_q} + {1'b0, inflight_q};
        in_ready  = occupancy < (CW + 1)'(DEPTH);
        acc       = in_valid & in_ready;
        arr       = tag_v_q[LAT-1];
        push      = arr;
        push_data = {tag_id_q[LAT-1], ge_exit_entry & ge_exit_zero};
        out_valid = count_q != '0;
        pop       = out_valid & out_ready;
        full      = count_q == CW'(DEPTH);
        out_id    = out_id_q;
        out_hit   = out_hit_q;
        hit_count = hit_count_q;
    end

    always_comb begin
        tag_v_d     = '0;
        tag_v_d[0]  = acc;
        tag_id_d[0] = in_id;
        for (int k = 1; k < LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({acc, arr})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // The head register follows the next head entry, forwarding a same-cycle write into an
    // empty (or draining-to-one) FIFO; it holds its last value while the FIFO is empty.
    always_comb begin
        out_id_d  = out_id_q;
        out_hit_d = out_hit_q;
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                {out_id_d, out_hit_d} = push_data;
            end else begin
                {out_id_d, out_hit_d} = mem_q[rd_ptr_d];
            end
        end
        hit_count_d = hit_count_q;
        if (pop && out_hit_q && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v_q     <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_id_q    <= '0;
            out_hit_q   <= 1'b0;
            hit_count_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id_q[k] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tag_v_q     <= tag_v_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_id_q    <= out_id_d;
            out_hit_q   <= out_hit_d;
            hit_count_q <= hit_count_d;
            for (int k = 0; k < LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // The credit scheme must never let an arriving result meet a full FIFO.
    assert property (@(posedge clk) disable iff (!rst) !(arr && full));

endmodule

// File: tb/tb_ray_aabb_hit_collector.sv
// Scoreboard bench for ray_aabb_hit_collector: the driver pushes expected {id, hit} on each
// accepted ray and schedules comparator flags LAT cycles later; a monitor pops and compares.
module tb_ray_aabb_hit_collector;

    localparam int LAT   = 3;
    localparam int ID_W  = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [ID_W-1:0] in_id = '0;
    logic            ge_exit_entry = 1'b0;
    logic            ge_exit_zero = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ID_W-1:0] out_id;
    logic            out_hit;
    logic [15:0]     hit_count;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            mon_hits = 0;
    logic [ID_W:0] exp_q [$];
    bit            sched_a [int];
    bit            sched_b [int];

    always #5 clk = ~clk;

    ray_aabb_hit_collector #(.LAT(LAT), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_id         (in_id),
        .ge_exit_entry (ge_exit_entry),
        .ge_exit_zero  (ge_exit_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_id        (out_id),
        .out_hit       (out_hit),
        .hit_count     (hit_count)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and drive the flags due for that cycle (random otherwise).
    task automatic step();
        @(negedge clk);
        cyc++;
        if (sched_a.exists(cyc)) begin
            ge_exit_entry = sched_a[cyc];
            ge_exit_zero  = sched_b[cyc];
            sched_a.delete(cyc);
            sched_b.delete(cyc);
        end else begin
            ge_exit_entry = 1'($urandom_range(0, 1));
            ge_exit_zero  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic apply_stimulus(input logic [ID_W-1:0] id, input bit a, input bit b, output bit acc);
        in_valid = 1'b1;
        in_id    = id;
        acc      = in_ready;
        if (acc) begin
            exp_q.push_back({id, a & b});
            sched_a[cyc + LAT] = a;
            sched_b[cyc + LAT] = b;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check_output("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    // Monitor: samples just before each rising edge so out_ready from the driver is settled.
    initial begin
        logic [ID_W:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                exp_q.delete();
                mon_hits = 0;
            end else if (out_valid && out_ready) begin
                check_output("hit_count_before_pop", 32'(hit_count), 32'(mon_hits));
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result: got id=0x%0h hit=%0b expected no result (cycle %0d)",
                             out_id, out_hit, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("out_id", 32'(out_id), 32'(e[ID_W:1]));
                    check_output("out_hit", 32'(out_hit), 32'(e[0]));
                    if (e[0] && mon_hits < 65535) mon_hits++;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        bit acc;
        int c0;
        int acc_n;

        // Reset values
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_out_id", 32'(out_id), 32'd0);
        check_output("rst_out_hit", 32'(out_hit), 32'd0);
        check_output("rst_hit_count", 32'(hit_count), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Single ray: latency LAT+1 to out_valid
        $display("[TB] single ray");
        out_ready = 1'b1;
        c0 = cyc;
        apply_stimulus(8'h2A, 1'b1, 1'b1, acc);
        check_output("single_accepted", 32'(acc), 32'd1);
        while (cyc < c0 + 3) step();
        check_output("single_c3_out_valid", 32'(out_valid), 32'd0);
        step();
        check_output("single_c4_out_valid", 32'(out_valid), 32'd1);
        check_output("single_c4_out_id", 32'(out_id), 32'h2A);
        check_output("single_c4_out_hit", 32'(out_hit), 32'd1);
        step();
        check_output("single_c5_out_valid", 32'(out_valid), 32'd0);
        check_output("single_c5_hit_count", 32'(hit_count), 32'd1);

        // Hit truth table
        $display("[TB] truth table");
        do_reset();
        apply_stimulus(8'h01, 1'b1, 1'b1, acc);
        apply_stimulus(8'h02, 1'b1, 1'b0, acc);
        apply_stimulus(8'h03, 1'b0, 1'b1, acc);
        apply_stimulus(8'h04, 1'b0, 1'b0, acc);
        drain();
        step();
        check_output("tt_hit_count", 32'(hit_count), 32'd1);
        check_output("tt_out_valid", 32'(out_valid), 32'd0);

        // Back-pressure
        $display("[TB] back-pressure");
        do_reset();
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(ID_W'(8'h10 + i), 1'(i), 1'b1, acc);
            acc_n += int'(acc);
        end
        check_output("bp_accepted", 32'(acc_n), 32'd4);
        check_output("bp_in_ready_full", 32'(in_ready), 32'd0);
        check_output("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        check_output("bp_in_ready_pop_cycle", 32'(in_ready), 32'd0);
        step();
        check_output("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
        drain();

        // Continuous stream of random tags
        $display("[TB] stream");
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_ready(ok);
            check_output("stream_ready", 32'(ok), 32'd1);
            apply_stimulus(ID_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
        end
        drain();

        // Mid-operation reset: 2 buffered + 2 in flight
        $display("[TB] mid-operation reset");
        do_reset();
        out_ready = 1'b0;
        apply_stimulus(8'h51, 1'b1, 1'b1, acc);
        apply_stimulus(8'h52, 1'b1, 1'b1, acc);
        step();
        step();
        step();
        check_output("mid_buffered_valid", 32'(out_valid), 32'd1);
        apply_stimulus(8'h53, 1'b1, 1'b1, acc);
        apply_stimulus(8'h54, 1'b1, 1'b1, acc);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_output("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_output("mid_rst_hit_count", 32'(hit_count), 32'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check_output("mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Saturation of hit_count
        $display("[TB] saturation");
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 65540; n++) begin
            wait_ready(ok);
            if (!ok) check_output("sat_ready", 32'(ok), 32'd1);
            apply_stimulus(ID_W'(n), 1'b1, 1'b1, acc);
        end
        drain();
        step();
        check_output("sat_hit_count", 32'(hit_count), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
